mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 2, meaning cycles from the memory sampling MemEn to MemRData being valid (legal range 1..15).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants tolerated while fetch waits (legal range 1..15).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port IReq, input, 1 bit: fetch requests a read.
REQ-006 The block SHALL have port IAddr, input, 32 bits: fetch byte address.
REQ-007 The block SHALL have port IValid, output, 1 bit: one-cycle fetch completion pulse.
REQ-008 The block SHALL have port IRData, output, 32 bits: fetch read data, valid with IValid.
REQ-009 The block SHALL have port IStall, output, 1 bit: freeze PC and IF/ID.
REQ-010 The block SHALL have port DReq, input, 1 bit: memory stage requests an access.
REQ-011 The block SHALL have port DWe, input, 1 bit: 1 = write, 0 = read.
REQ-012 The block SHALL have port DAddr, input, 32 bits: data byte address.
REQ-013 The block SHALL have port DWData, input, 32 bits: store data.
REQ-014 The block SHALL have port DValid, output, 1 bit: one-cycle data completion pulse, for reads and writes.
REQ-015 The block SHALL have port DRData, output, 32 bits: load data, valid with DValid.
REQ-016 The block SHALL have port DStall, output, 1 bit: freeze all pipeline registers up to EX/MEM.
REQ-017 The block SHALL have port MemEn, output, 1 bit: one-cycle access strobe to the shared single-port memory.
REQ-018 The block SHALL have port MemWe, output, 1 bit: write strobe, qualified by MemEn.
REQ-019 The block SHALL have port MemAddr, output, 32 bits: memory address.
REQ-020 The block SHALL have port MemWData, output, 32 bits: memory write data.
REQ-021 The block SHALL have port MemRData, input, 32 bits: memory read data.

Function
REQ-022 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D; only IDLE arbitrates, so at most one transaction is in flight.
REQ-023 When IDLE samples a request at edge t, MemEn, MemWe, MemAddr and MemWData SHALL be registered and high during cycle t+1 only, and the latency counter SHALL load MEM_LATENCY.
REQ-024 In cycle t+1+MEM_LATENCY the block SHALL capture MemRData; in cycle t+2+MEM_LATENCY it SHALL pulse xValid with xRData and return to IDLE. With default parameters, a request in cycle 0 gives Valid in cycle 4.
REQ-025 A request SHALL be re-arbitrated in the same cycle as the previous Valid, so the back-to-back spacing is MEM_LATENCY+2 cycles.
REQ-026 When IReq and DReq are both set in IDLE, DReq SHALL win unless the starvation override (REQ-033) applies.
REQ-027 Requesters SHALL hold Req and payload until Valid; a Req dropped mid-flight SHALL still complete and pulse Valid.
REQ-028 IStall SHALL equal IReq & ~IValid, combinationally.
REQ-029 DStall SHALL equal DReq & ~DValid, combinationally.
REQ-030 A write SHALL leave DRData at its previous value.
REQ-031 IRData and DRData SHALL hold their last captured value between pulses.

Reset
REQ-032 While Rst=0, the state SHALL be IDLE, the counters 0, and every output 0, including any in-flight transaction; a read aborted by reset SHALL produce no Valid after release.

Configuration
REQ-033 When macro ARB_STARVE_GUARD_EN is defined, a counter SHALL count D grants issued while IReq=1, clear on any I grant, and force an I grant at the next arbitration once it reaches STARVE_LIMIT.
REQ-034 When ARB_STARVE_GUARD_EN is not defined, arbitration SHALL use strict D priority and contain no starvation counter.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state encoding, the 4-bit counter width and the default MEM_LATENCY and STARVE_LIMIT.
REQ-036 The latency down-counter SHALL be a sub-module, arb_lat_counter, with load, decrement and zero-flag.

Verification
REQ-037 The bench SHALL cover: IReq=1 with IAddr=0x40 in cycle 0, MemRData=0x8C010004 -> MemEn in cycle 1, IValid and IRData=0x8C010004 in cycle 4, IStall high in cycles 0-3.
REQ-038 The bench SHALL cover: IReq and DReq set together, DWe=1, DAddr=0x100, DWData=0xDEADBEEF -> D granted first with MemWe=1 in cycle 1, DValid in cycle 4, IValid in cycle 8.
REQ-039 The bench SHALL cover, with the macro defined: DReq and IReq held continuously -> I granted after exactly 4 D grants; without the macro -> I never granted.
REQ-040 The bench SHALL cover: Rst=0 in cycle 2 of a read -> all outputs 0 immediately, no Valid after release, next request restarts with the full latency.
REQ-041 The bench SHALL cover: MEM_LATENCY=1 with back-to-back D reads -> MemEn in cycles 1 and 4, DValid in cycles 3 and 6.
REQ-042 The bench SHALL cover: DReq dropped in cycle 2 of a read -> DValid still pulses in cycle 4 and DStall is 0 from cycle 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

  localparam int CNT_W            = 4;
  localparam int DEF_MEM_LATENCY  = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  function automatic logic [CNT_W-1:0] to_cnt(int v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// rtl/arb_lat_counter.sv - memory latency down-counter with load, decrement and zero flag
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory
// Optional fetch starvation guard enabled by macro ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IValid,
  output logic [31:0] IRData,
  output logic        IStall,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DValid,
  output logic [31:0] DRData,
  output logic        DStall,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  localparam logic [CNT_W-1:0] LAT = to_cnt(MEM_LATENCY);

  arb_state_e  state_q;
  logic        mem_en_q, mem_we_q, wr_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        i_valid_q, d_valid_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        idle, grant_d, grant_i, force_i, lat_zero;

  assign idle    = (state_q == IDLE);
  assign grant_d = DReq & ~force_i;
  assign grant_i = IReq & ~grant_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] STARVE_LIM = to_cnt(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (idle && grant_i) begin
      starve_d = '0;
    end else if (idle && grant_d && IReq && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_i = IReq & (starve_q >= STARVE_LIM);
`else
  assign force_i = 1'b0;
`endif

  arb_lat_counter u_lat (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .load_i     (idle & (grant_d | grant_i)),
    .dec_i      (~idle),
    .load_val_i (LAT),
    .zero_o     (lat_zero)
  );

  // Memory strobes and valid pulses default low every cycle: one-cycle by construction.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_q        <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= BUSY_D;
            mem_en_q    <= 1'b1;
            mem_we_q    <= DWe;
            mem_addr_q  <= DAddr;
            mem_wdata_q <= DWData;
            wr_q        <= DWe;
          end else if (grant_i) begin
            state_q    <= BUSY_I;
            mem_en_q   <= 1'b1;
            mem_addr_q <= IAddr;
            wr_q       <= 1'b0;
          end
        end
        BUSY_I: begin
          if (lat_zero) begin
            i_rdata_q <= MemRData;
            i_valid_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        BUSY_D: begin
          if (lat_zero) begin
            if (!wr_q) begin
              d_rdata_q <= MemRData;
            end
            d_valid_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemEn    = mem_en_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign IValid   = i_valid_q;
  assign IRData   = i_rdata_q;
  assign DValid   = d_valid_q;
  assign DRData   = d_rdata_q;

  // Reset forces every output low, the stalls included.
  assign IStall = Rst & IReq & ~i_valid_q;
  assign DStall = Rst & DReq & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        Clk = 1'b0, Rst = 1'b0, IReq = 1'b0, DReq = 1'b0, DWe = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0, mem_val = '0;

  logic        i_valid, i_stall, d_valid, d_stall, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        l1_i_valid, l1_i_stall, l1_d_valid, l1_d_stall, l1_mem_en, l1_mem_we;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  logic [1:0]  pipe2 = '0;
  logic        pipe1 = 1'b0;
  int vectors = 0, miscompares = 0;

  always #5 Clk = ~Clk;

  // Memory model: data is only valid in the cycle the latency says, garbage otherwise.
  always @(posedge Clk) begin
    pipe2 <= {pipe2[0], mem_en};
    pipe1 <= l1_mem_en;
  end
  assign mem_rdata    = pipe2[1] ? mem_val : 32'hBAD0_BAD0;
  assign l1_mem_rdata = pipe1    ? mem_val : 32'hBAD0_BAD0;

  mem_port_arbiter dut (
    .Clk(Clk), .Rst(Rst), .IReq(IReq), .IAddr(IAddr), .IValid(i_valid), .IRData(i_rdata),
    .IStall(i_stall), .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DValid(d_valid), .DRData(d_rdata), .DStall(d_stall), .MemEn(mem_en), .MemWe(mem_we),
    .MemAddr(mem_addr), .MemWData(mem_wdata), .MemRData(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .Clk(Clk), .Rst(Rst), .IReq(IReq), .IAddr(IAddr), .IValid(l1_i_valid), .IRData(l1_i_rdata),
    .IStall(l1_i_stall), .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DValid(l1_d_valid), .DRData(l1_d_rdata), .DStall(l1_d_stall), .MemEn(l1_mem_en),
    .MemWe(l1_mem_we), .MemAddr(l1_mem_addr), .MemWData(l1_mem_wdata), .MemRData(l1_mem_rdata)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; IReq = 1'b1; DReq = 1'b1;
    @(negedge Clk);
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    vectors++; if (i_stall !== 1'b0) begin miscompares++; $display("FAIL rst_i_stall got %b exp 0", i_stall); end
    vectors++; if (d_stall !== 1'b0) begin miscompares++; $display("FAIL rst_d_stall got %b exp 0", d_stall); end
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL rst_i_valid got %b exp 0", i_valid); end
    vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
    IReq = 1'b0; DReq = 1'b0;
    tick();
    Rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_ifetch();
    IAddr = 32'h40; mem_val = 32'h8C01_0004;
    for (int c = 0; c < 6; c++) begin
      IReq = (c < 4);
      @(negedge Clk);
      vectors++; if (i_stall !== (c < 4)) begin miscompares++; $display("FAIL if_i_stall c%0d got %b exp %b", c, i_stall, c < 4); end
      vectors++; if (mem_en !== (c == 1)) begin miscompares++; $display("FAIL if_mem_en c%0d got %b exp %b", c, mem_en, c == 1); end
      vectors++; if (i_valid !== (c == 4)) begin miscompares++; $display("FAIL if_i_valid c%0d got %b exp %b", c, i_valid, c == 4); end
      if (c == 1) begin
        vectors++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin miscompares++; $display("FAIL if_mem_addr got %h/%b exp 00000040/0", mem_addr, mem_we); end
      end
      if (c >= 4) begin
        vectors++; if (i_rdata !== 32'h8C01_0004) begin miscompares++; $display("FAIL if_i_rdata c%0d got %h exp 8c010004", c, i_rdata); end
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_drop();
    DWe = 1'b0; DAddr = 32'h200; mem_val = 32'h5A5A_0001;
    for (int c = 0; c < 6; c++) begin
      DReq = (c < 2);
      @(negedge Clk);
      vectors++; if (d_stall !== (c < 2)) begin miscompares++; $display("FAIL drop_d_stall c%0d got %b exp %b", c, d_stall, c < 2); end
      vectors++; if (d_valid !== (c == 4)) begin miscompares++; $display("FAIL drop_d_valid c%0d got %b exp %b", c, d_valid, c == 4); end
      vectors++; if (mem_en !== (c == 1)) begin miscompares++; $display("FAIL drop_mem_en c%0d got %b exp %b", c, mem_en, c == 1); end
      if (c == 4) begin
        vectors++; if (d_rdata !== 32'h5A5A_0001) begin miscompares++; $display("FAIL drop_d_rdata got %h exp 5a5a0001", d_rdata); end
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_priority();
    IAddr = 32'h80; DWe = 1'b1; DAddr = 32'h100; DWData = 32'hDEAD_BEEF; mem_val = 32'h1111_2222;
    for (int c = 0; c < 10; c++) begin
      DReq = (c < 4); IReq = (c < 8);
      @(negedge Clk);
      vectors++; if (d_valid !== (c == 4)) begin miscompares++; $display("FAIL pri_d_valid c%0d got %b exp %b", c, d_valid, c == 4); end
      vectors++; if (i_valid !== (c == 8)) begin miscompares++; $display("FAIL pri_i_valid c%0d got %b exp %b", c, i_valid, c == 8); end
      vectors++; if (d_stall !== (c < 4) || i_stall !== (c < 8)) begin miscompares++; $display("FAIL pri_stalls c%0d got %b%b exp %b%b", c, d_stall, i_stall, c < 4, c < 8); end
      vectors++; if (mem_en !== (c == 1 || c == 5)) begin miscompares++; $display("FAIL pri_mem_en c%0d got %b exp %b", c, mem_en, c == 1 || c == 5); end
      if (c == 1) begin
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL pri_d_write got %b/%h/%h exp 1/00000100/deadbeef", mem_we, mem_addr, mem_wdata); end
      end
      if (c == 5) begin
        vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'h80) begin miscompares++; $display("FAIL pri_i_read got %b/%h exp 0/00000080", mem_we, mem_addr); end
      end
      if (c == 8) begin
        vectors++; if (i_rdata !== 32'h1111_2222) begin miscompares++; $display("FAIL pri_i_rdata got %h exp 11112222", i_rdata); end
      end
      if (c >= 4) begin
        vectors++; if (d_rdata !== 32'h5A5A_0001) begin miscompares++; $display("FAIL pri_write_keeps_rdata c%0d got %h exp 5a5a0001", c, d_rdata); end
      end
      tick();
    end
    DWe = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    DWe = 1'b0; DAddr = 32'h500;
    for (int c = 0; c < 8; c++) begin
      DReq = (c < 4);
      mem_val = 32'hA000_0000 + 32'(c);
      @(negedge Clk);
      vectors++; if (l1_mem_en !== (c == 1 || c == 4)) begin miscompares++; $display("FAIL b2b_mem_en c%0d got %b exp %b", c, l1_mem_en, c == 1 || c == 4); end
      vectors++; if (l1_d_valid !== (c == 3 || c == 6)) begin miscompares++; $display("FAIL b2b_d_valid c%0d got %b exp %b", c, l1_d_valid, c == 3 || c == 6); end
      if (c == 3) begin
        vectors++; if (l1_d_rdata !== 32'hA000_0002) begin miscompares++; $display("FAIL b2b_rdata0 got %h exp a0000002", l1_d_rdata); end
      end
      if (c == 6) begin
        vectors++; if (l1_d_rdata !== 32'hA000_0005) begin miscompares++; $display("FAIL b2b_rdata1 got %h exp a0000005", l1_d_rdata); end
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_starvation();
    int d_cnt = 0, d_before_i = 0;
    bit i_seen = 0;
    DWe = 1'b0; DAddr = 32'h300; IAddr = 32'h400; mem_val = 32'h3333_0000;
    DReq = 1'b1; IReq = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (mem_en && mem_addr == 32'h400 && !i_seen) begin
        i_seen = 1; d_before_i = d_cnt;
      end else if (mem_en && mem_addr == 32'h300) begin
        d_cnt++;
      end
      tick();
    end
    DReq = 1'b0; IReq = 1'b0;
    repeat (6) tick();
`ifdef ARB_STARVE_GUARD_EN
    vectors++; if (i_seen !== 1'b1) begin miscompares++; $display("FAIL starve_i_granted got %b exp 1", i_seen); end
    vectors++; if (d_before_i != 4) begin miscompares++; $display("FAIL starve_d_before_i got %0d exp 4", d_before_i); end
`else
    vectors++; if (i_seen !== 1'b0) begin miscompares++; $display("FAIL starve_i_granted got %b exp 0", i_seen); end
    vectors++; if (d_cnt != 8) begin miscompares++; $display("FAIL starve_d_grants got %0d exp 8", d_cnt); end
`endif
  endtask

  task automatic test_reset_abort();
    DWe = 1'b0; DAddr = 32'h600; mem_val = 32'h7777_0000; DReq = 1'b1;
    tick();
    @(negedge Clk);
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL abort_mem_en got %b exp 1", mem_en); end
    tick();
    Rst = 1'b0;
    #1;
    vectors++; if ({mem_en, mem_we, d_valid, d_stall, i_valid, i_stall} !== 6'b0) begin miscompares++; $display("FAIL abort_ctrl got %b exp 000000", {mem_en, mem_we, d_valid, d_stall, i_valid, i_stall}); end
    vectors++; if (d_rdata !== 32'h0 || i_rdata !== 32'h0) begin miscompares++; $display("FAIL abort_rdata got %h/%h exp 0/0", d_rdata, i_rdata); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL abort_mem_addr got %h exp 0", mem_addr); end
    DReq = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    for (int c = 4; c < 10; c++) begin
      @(negedge Clk);
      vectors++; if (d_valid !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL abort_quiet c%0d got %b%b exp 00", c, d_valid, mem_en); end
      tick();
    end
    DAddr = 32'h604;
    for (int c = 0; c < 6; c++) begin
      DReq = (c < 4);
      @(negedge Clk);
      vectors++; if (mem_en !== (c == 1)) begin miscompares++; $display("FAIL restart_mem_en c%0d got %b exp %b", c, mem_en, c == 1); end
      vectors++; if (d_valid !== (c == 4)) begin miscompares++; $display("FAIL restart_d_valid c%0d got %b exp %b", c, d_valid, c == 4); end
      if (c == 4) begin
        vectors++; if (d_rdata !== 32'h7777_0000) begin miscompares++; $display("FAIL restart_d_rdata got %h exp 77770000", d_rdata); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_drop();
    test_priority();
    test_back_to_back();
    test_starvation();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
